// File: rtl/qmult_if.sv
// Operand/result bundle for the Q-format multiplier.
// The master side presents operands with a valid strobe and observes the
// saturated product; the slave side is the multiplier itself.
interface qmult_if #(
    parameter int N = 32
);
    logic         i_valid;
    logic [N-1:0] i_multiplicand;
    logic [N-1:0] i_multiplier;
    logic [N-1:0] o_result;
    logic         o_overflow;
    logic         o_valid;

    modport master (
        output i_valid,
        output i_multiplicand,
        output i_multiplier,
        input  o_result,
        input  o_overflow,
        input  o_valid
    );

    modport slave (
        input  i_valid,
        input  i_multiplicand,
        input  i_multiplier,
        output o_result,
        output o_overflow,
        output o_valid
    );
endinterface

// File: rtl/qmult.sv
// Signed fixed-point multiplier, Q(N-Q-1).Q in and out.
// Two-stage pipeline: stage 1 registers the operands, stage 2 registers the
// product rescaled by 2^-Q (floor), saturated to the N-bit range with an
// overflow flag. The pipeline advances every cycle; there is no backpressure.
module qmult #(
    parameter int Q = 18,
    parameter int N = 32
) (
    input  logic   clk,
    input  logic   reset,
    qmult_if.slave bus
);
    // Bits of the full product above the kept window (including the kept
    // sign bit). The product fits in N bits only if these all agree.
    localparam int HEAD_W = N + 1 - Q;

    logic signed [N-1:0]   a_r;
    logic signed [N-1:0]   b_r;
    logic                  valid_r;

    logic signed [2*N-1:0] full;
    logic [HEAD_W-1:0]     head;
    logic                  pos_sat;
    logic                  neg_sat;
    logic [N-1:0]          result_next;
    logic                  overflow_next;
    logic                  unused_frac;

    logic [N-1:0]          result_r;
    logic                  overflow_r;
    logic                  valid_out_r;

    // Stage 1: capture operands and their valid strobe every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r     <= '0;
            b_r     <= '0;
            valid_r <= 1'b0;
        end else begin
            a_r     <= bus.i_multiplicand;
            b_r     <= bus.i_multiplier;
            valid_r <= bus.i_valid;
        end
    end

    // Operands are sign-extended to 2N so the product is exact; it carries
    // 2Q fractional bits and cannot exceed 2N bits for two N-bit inputs.
    assign full = $signed({{N{a_r[N-1]}}, a_r}) * $signed({{N{b_r[N-1]}}, b_r});

    // Dropping the low Q bits of a two's-complement value is an arithmetic
    // shift, i.e. truncation toward minus infinity; no rounding is applied.
    assign head        = full[2*N-1 : N-1+Q];
    assign unused_frac = ^full[Q-1:0];

    // A positive product overflows if any bit above the kept sign bit is set;
    // a negative one if any of those bits is clear.
    assign pos_sat = ~full[2*N-1] & (|head);
    assign neg_sat =  full[2*N-1] & ~(&head);

    // Pick the kept window or the saturation limit for the stage-2 register.
    always_comb begin
        result_next   = full[N-1+Q : Q];
        overflow_next = 1'b0;
        if (pos_sat) begin
            result_next   = {1'b0, {(N-1){1'b1}}};
            overflow_next = 1'b1;
        end else if (neg_sat) begin
            result_next   = {1'b1, {(N-1){1'b0}}};
            overflow_next = 1'b1;
        end
    end

    // Stage 2: register the saturated product, overflow flag and valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_r    <= '0;
            overflow_r  <= 1'b0;
            valid_out_r <= 1'b0;
        end else begin
            result_r    <= result_next;
            overflow_r  <= overflow_next;
            valid_out_r <= valid_r;
        end
    end

    assign bus.o_result   = result_r;
    assign bus.o_overflow = overflow_r;
    assign bus.o_valid    = valid_out_r;
endmodule

// File: tb/tb_qmult.sv
// Self-checking bench for qmult with N=32, Q=18 (1.0 = 0x0004_0000).
// Directed table of hand-computed products with an exact latency check,
// streaming with a valid gap, asynchronous mid-stream reset, and a random
// regression against a 64-bit saturate(floor(A*B/2^Q)) model.
module tb_qmult;
    localparam int N = 32;
    localparam int Q = 18;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -MAXV - 64'sd1;

    logic clk = 1'b0;
    logic reset;

    qmult_if #(.N(N)) bus ();

    qmult #(.Q(Q), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        ovf;
    } vec_t;

    vec_t vecs [18];

    // Expected outputs for the inputs driven one and two negedges ago.
    logic        d1_v, d2_v;
    logic [31:0] d1_r, d2_r;
    logic        d1_o, d2_o;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b);
        bus.i_valid        = v;
        bus.i_multiplicand = a;
        bus.i_multiplier   = b;
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic o);
        longint pa, pb, p, s;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        p  = pa * pb;
        s  = p >>> Q;
        if (s > MAXV) begin
            r = 32'h7FFF_FFFF;
            o = 1'b1;
        end else if (s < MINV) begin
            r = 32'h8000_0000;
            o = 1'b1;
        end else begin
            r = s[31:0];
            o = 1'b0;
        end
    endfunction

    // One streaming cycle: check what was driven two negedges ago, then drive.
    task automatic step(input string tag, input logic v, input logic [31:0] a,
                        input logic [31:0] b);
        logic [31:0] er;
        logic        eo;
        @(negedge clk);
        checkOutput({tag, " valid"}, {31'd0, bus.o_valid}, {31'd0, d2_v});
        if (d2_v) begin
            checkOutput({tag, " result"}, bus.o_result, d2_r);
            checkOutput({tag, " overflow"}, {31'd0, bus.o_overflow}, {31'd0, d2_o});
        end
        model(a, b, er, eo);
        d2_v = d1_v; d2_r = d1_r; d2_o = d1_o;
        d1_v = v;    d1_r = er;   d1_o = eo;
        applyStimulus(v, a, b);
    endtask

    // Global time bound so the run always ends.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rv;

        vecs[0]  = '{32'h0006_0000, 32'h0008_0000, 32'h000C_0000, 1'b0};
        vecs[1]  = '{32'hFFFA_0000, 32'h0008_0000, 32'hFFF4_0000, 1'b0};
        vecs[2]  = '{32'h0190_0000, 32'h0190_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[3]  = '{32'hFE70_0000, 32'h0190_0000, 32'h8000_0000, 1'b1};
        vecs[4]  = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[5]  = '{32'h0000_0001, 32'h0002_0000, 32'h0000_0000, 1'b0};
        vecs[6]  = '{32'hFFFF_FFFF, 32'h0002_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[7]  = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0};
        vecs[8]  = '{32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[9]  = '{32'h7FFF_FFFF, 32'h0004_0000, 32'h7FFF_FFFF, 1'b0};
        vecs[10] = '{32'h8000_0000, 32'h0004_0000, 32'h8000_0000, 1'b0};
        vecs[11] = '{32'h8000_0000, 32'hFFFC_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[12] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_2000, 1'b0};
        vecs[13] = '{32'h0002_0000, 32'h0002_0000, 32'h0001_0000, 1'b0};
        vecs[14] = '{32'hFFFC_0000, 32'hFFFC_0000, 32'h0004_0000, 1'b0};
        vecs[15] = '{32'h000C_0000, 32'hFFFF_0000, 32'hFFFD_0000, 1'b0};
        vecs[16] = '{32'h7FFF_FFFF, 32'h0004_0001, 32'h7FFF_FFFF, 1'b1};
        vecs[17] = '{32'h8000_0000, 32'h0003_FFFF, 32'h8000_2000, 1'b0};

        // Power-up in reset.
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset valid", {31'd0, bus.o_valid}, 32'd0);
        checkOutput("reset result", bus.o_result, 32'd0);
        checkOutput("reset overflow", {31'd0, bus.o_overflow}, 32'd0);
        reset = 1'b1;

        // Directed table with an exact 2-cycle latency check per vector.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            applyStimulus(1'b1, vecs[i].a, vecs[i].b);
            @(negedge clk);
            checkOutput($sformatf("vec%0d early valid", i), {31'd0, bus.o_valid}, 32'd0);
            applyStimulus(1'b0, 32'h0, 32'h0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d valid", i), {31'd0, bus.o_valid}, 32'd1);
            checkOutput($sformatf("vec%0d result", i), bus.o_result, vecs[i].r);
            checkOutput($sformatf("vec%0d overflow", i), {31'd0, bus.o_overflow},
                        {31'd0, vecs[i].ovf});
        end

        // Streaming: 4 back-to-back, one-cycle gap, 2 more, then flush.
        d1_v = 1'b0; d2_v = 1'b0;
        d1_r = '0;   d2_r = '0;
        d1_o = 1'b0; d2_o = 1'b0;
        step("stream0", 1'b1, vecs[0].a, vecs[0].b);
        step("stream1", 1'b1, vecs[2].a, vecs[2].b);
        step("stream2", 1'b1, vecs[5].a, vecs[5].b);
        step("stream3", 1'b1, vecs[6].a, vecs[6].b);
        step("stream4", 1'b0, 32'h1234_5678, 32'h0004_0000);
        step("stream5", 1'b1, vecs[1].a, vecs[1].b);
        step("stream6", 1'b1, vecs[11].a, vecs[11].b);
        step("stream7", 1'b0, 32'h0, 32'h0);
        step("stream8", 1'b0, 32'h0, 32'h0);
        step("stream9", 1'b0, 32'h0, 32'h0);

        // Asynchronous reset with the pipeline full of nonzero data.
        step("prerst0", 1'b1, vecs[0].a, vecs[0].b);
        step("prerst1", 1'b1, vecs[3].a, vecs[3].b);
        step("prerst2", 1'b1, vecs[1].a, vecs[1].b);
        @(posedge clk);
        #2;
        checkOutput("prerst live valid", {31'd0, bus.o_valid}, 32'd1);
        reset = 1'b0;
        bus.i_valid = 1'b0;
        #1;
        checkOutput("async rst valid", {31'd0, bus.o_valid}, 32'd0);
        checkOutput("async rst result", bus.o_result, 32'd0);
        checkOutput("async rst overflow", {31'd0, bus.o_overflow}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        d1_v = 1'b0; d2_v = 1'b0;
        step("postrst0", 1'b0, 32'h0, 32'h0);
        step("postrst1", 1'b0, 32'h0, 32'h0);
        step("postrst2", 1'b1, vecs[15].a, vecs[15].b);
        step("postrst3", 1'b0, 32'h0, 32'h0);
        step("postrst4", 1'b0, 32'h0, 32'h0);
        step("postrst5", 1'b0, 32'h0, 32'h0);

        // Random regression with mixed operand magnitudes.
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            ra = 32'($signed(ra) >>> $urandom_range(0, 20));
            rb = 32'($signed(rb) >>> $urandom_range(0, 20));
            rv = ($urandom_range(0, 3) != 0);
            step($sformatf("rand%0d", i), rv, ra, rb);
        end
        step("randflush0", 1'b0, 32'h0, 32'h0);
        step("randflush1", 1'b0, 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
